// File: rtl/kbd_ctrl.sv
// PS/2 keyboard port sequencer: forwards received bytes through a one-byte holding
// register and transmits host-to-device commands with ACK, response handling and retry.
module kbd_ctrl #(
   parameter int unsigned INHIBIT_CYC = 5000,
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_byte,
   output logic       cmd_ready,
   output logic       busy,
   output logic       err,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       rx_done,
   output logic       rx_clr,
   output logic       out_rdy,
   output logic [7:0] out_data,
   input  logic       out_done,
   input  logic       kbd_clk_in,
   input  logic       kbd_data_in,
   output logic       kbd_clk_oe,
   output logic       kbd_data_oe
);

   localparam int unsigned CntMax = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned RtyW   = $clog2(MAX_RETRY + 2);

   typedef enum logic [2:0] {
      StIdle, StInhibit, StTx, StAckbit, StWaitResp, StRetry
   } state_e;

   state_e          st_q, st_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [RtyW-1:0] retry_q, retry_d;
   logic [3:0]      bit_q, bit_d;
   logic [7:0]      cmd_q, cmd_d;
   logic            par_q, par_d;
   logic            data_oe_q, data_oe_d;
   logic            err_q, err_d;
   logic            hold_full_q, hold_full_d;
   logic [7:0]      hold_q, hold_d;
   logic [2:0]      kclk_sync_q;
   logic [1:0]      kdat_sync_q;
   logic            clk_fall;
   logic            timeout;

   // Sync stages reset high so an idle line never looks like a falling edge.
   assign clk_fall = kclk_sync_q[2] & ~kclk_sync_q[1];
   assign timeout  = (cnt_q == CntW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= StIdle;
         cnt_q       <= '0;
         retry_q     <= '0;
         bit_q       <= '0;
         cmd_q       <= '0;
         par_q       <= 1'b0;
         data_oe_q   <= 1'b0;
         err_q       <= 1'b0;
         hold_full_q <= 1'b0;
         hold_q      <= '0;
         kclk_sync_q <= '1;
         kdat_sync_q <= '1;
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         bit_q       <= bit_d;
         cmd_q       <= cmd_d;
         par_q       <= par_d;
         data_oe_q   <= data_oe_d;
         err_q       <= err_d;
         hold_full_q <= hold_full_d;
         hold_q      <= hold_d;
         kclk_sync_q <= {kclk_sync_q[1:0], kbd_clk_in};
         kdat_sync_q <= {kdat_sync_q[0], kbd_data_in};
      end
   end

   always_comb begin
      st_d        = st_q;
      cnt_d       = cnt_q + CntW'(1);
      retry_d     = retry_q;
      bit_d       = bit_q;
      cmd_d       = cmd_q;
      par_d       = par_q;
      data_oe_d   = data_oe_q;
      err_d       = err_q;
      hold_full_d = hold_full_q;
      hold_d      = hold_q;
      cmd_ready   = 1'b0;
      rx_done     = 1'b0;
      rx_clr      = 1'b0;
      kbd_clk_oe  = 1'b0;
      kbd_data_oe = data_oe_q;

      if (out_done && hold_full_q) hold_full_d = 1'b0;

      unique case (st_q)
         StIdle: begin
            cnt_d     = '0;
            cmd_ready = ~rx_rdy;
            if (rx_rdy && !hold_full_q) begin
               rx_done     = 1'b1;
               hold_d      = rx_data;
               hold_full_d = 1'b1;
            end else if (cmd_valid && !rx_rdy) begin
               cmd_d   = cmd_byte;
               par_d   = ~^cmd_byte;
               err_d   = 1'b0;
               retry_d = '0;
               st_d    = StInhibit;
            end
         end
         StInhibit: begin
            kbd_clk_oe = 1'b1;
            rx_done    = rx_rdy;
            if (cnt_q == CntW'(INHIBIT_CYC - 1)) begin
               kbd_data_oe = 1'b1;
               data_oe_d   = 1'b1;
               bit_d       = '0;
               st_d        = StTx;
            end
         end
         StTx: begin
            rx_done = rx_rdy;
            if (clk_fall) begin
               cnt_d = '0;
               bit_d = bit_q + 4'd1;
               if (bit_q < 4'd8) begin
                  data_oe_d = ~cmd_q[bit_q[2:0]];
               end else if (bit_q == 4'd8) begin
                  data_oe_d = ~par_q;
               end else begin
                  data_oe_d = 1'b0;
                  st_d      = StAckbit;
               end
            end else if (timeout) begin
               st_d = StRetry;
            end
         end
         StAckbit: begin
            rx_done = rx_rdy;
            if (clk_fall) begin
               if (!kdat_sync_q[1]) begin
                  rx_clr = 1'b1;
                  st_d   = StWaitResp;
               end else begin
                  st_d = StRetry;
               end
            end else if (timeout) begin
               st_d = StRetry;
            end
         end
         StWaitResp: begin
            if (hold_full_q) begin
               cnt_d = cnt_q;
            end else if (rx_rdy) begin
               rx_done = 1'b1;
               if (rx_data == 8'hFA) begin
                  st_d = StIdle;
               end else if (rx_data == 8'hFE) begin
                  st_d = StRetry;
               end else begin
                  hold_d      = rx_data;
                  hold_full_d = 1'b1;
               end
            end else if (timeout) begin
               st_d = StRetry;
            end
         end
         StRetry: begin
            kbd_data_oe = 1'b0;
            data_oe_d   = 1'b0;
            if (retry_q < RtyW'(MAX_RETRY)) begin
               retry_d = retry_q + RtyW'(1);
               st_d    = StInhibit;
            end else begin
               err_d = 1'b1;
               st_d  = StIdle;
            end
         end
         default: st_d = StIdle;
      endcase

      if (st_d != st_q) cnt_d = '0;

      // Keep handshake outputs quiet while reset is held.
      if (rst) begin
         cmd_ready = 1'b0;
         rx_done   = 1'b0;
      end
   end

   assign busy     = (st_q != StIdle);
   assign err      = err_q;
   assign out_rdy  = hold_full_q;
   assign out_data = hold_q;

endmodule
